// File: rtl/nios_system_pio_keys_irq.sv
// Key-input PIO: per-bit synchroniser, optional debounce, edge capture and a maskable level irq.
// Debounce counters are built only when PIO_KEYS_DEBOUNCE_EN is defined; otherwise data follows the synchroniser.
module nios_system_pio_keys_irq #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter int unsigned IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] data_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] clr_c;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  assign sync_out     = sync_q[SYNC_STAGES-1];
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Synchroniser shift chain, newest sample in stage 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{IDLE_VEC}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end

`ifdef PIO_KEYS_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // A new level is accepted only after holding for DEBOUNCE_CYCLES; any bounce restarts the count.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync_out[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        data_d[i] = sync_out[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  localparam int unsigned UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;

  always_comb begin
    data_d = sync_out;
  end
`endif

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_c = data_q & ~data_dly_q;
      1:       edge_c = ~data_q & data_dly_q;
      default: edge_c = data_q ^ data_dly_q;
    endcase
  end

  // Register writes; a same-cycle edge beats write-1-to-clear.
  always_comb begin
    mask_d = mask_q;
    clr_c  = '0;
    if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE) clr_c  = writedata[WIDTH-1:0];
    edge_cap_d = (edge_cap_q & ~clr_c) | edge_c;
    irq_d      = |(edge_cap_q & mask_q);
  end

  always_comb begin
    case (address)
      ADDR_DATA: rdata_d = 32'(data_q);
      ADDR_MASK: rdata_d = 32'(mask_q);
      ADDR_EDGE: rdata_d = 32'(edge_cap_q);
      default:   rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= IDLE_VEC;
      data_dly_q <= IDLE_VEC;
      mask_q     <= '0;
      edge_cap_q <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      data_dly_q <= data_q;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_system_pio_keys_irq.sv
// Directed bench for nios_system_pio_keys_irq: register-map vector table plus timing sequences.
module tb_nios_system_pio_keys_irq;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
`ifdef PIO_KEYS_DEBOUNCE_EN
  localparam int L = SYNC + DEB;
  localparam logic [31:0] BOUNCE_EDGE = 32'h0;
`else
  localparam int L = SYNC + 1;
  localparam logic [31:0] BOUNCE_EDGE = 32'h2;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  nios_system_pio_keys_irq #(
    .WIDTH(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(1), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr_cycle(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    vecs[0] = '{2'd0, 1'b0, 32'h0,        32'h0000000F, 1'b0};
    vecs[1] = '{2'd1, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[2] = '{2'd2, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[3] = '{2'd3, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[4] = '{2'd1, 1'b1, 32'hFFFFFFF5, 32'h5,        1'b0};
    vecs[5] = '{2'd0, 1'b1, 32'h0,        32'h0000000F, 1'b0};
    vecs[6] = '{2'd2, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[7] = '{2'd3, 1'b1, 32'hF,        32'h0,        1'b0};
    vecs[8] = '{2'd1, 1'b1, 32'h0,        32'h0,        1'b0};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'h0; in_port = 4'hF;
    repeat (2) @(negedge clk);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Register map: optional write, then read back the same address.
    for (int i = 0; i < 9; i++) begin
      address = vecs[i].addr;
      if (vecs[i].wr) begin
        writedata = vecs[i].wdata; chipselect = 1'b1; write_n = 1'b0;
      end
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Clean falling step on bit0.
    address = 2'd0;
    in_port = 4'hE;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      if (k == L)     check("step_hold", {31'b0, readdata[0]}, 32'h1);
      if (k == L + 1) check("step_fall", {31'b0, readdata[0]}, 32'h0);
    end
    address = 2'd3;
    @(negedge clk);
    check("step_edge", readdata, 32'h1);
    check("step_irq_masked", {31'b0, irq}, 32'h0);
    wr_cycle(2'd3, 32'h1);
    @(negedge clk);
    check("step_clear", readdata, 32'h0);
    in_port = 4'hF;
    repeat (L + 3) @(negedge clk);
    check("rise_ignored", readdata, 32'h0);
    address = 2'd0;
    @(negedge clk);
    check("release_data", readdata, 32'hF);

    // Bounce on bit1: 7 low, 3 high, 7 low.
    in_port = 4'hD; repeat (7) @(negedge clk);
    in_port = 4'hF; repeat (3) @(negedge clk);
    in_port = 4'hD; repeat (7) @(negedge clk);
    in_port = 4'hF; repeat (L + 4) @(negedge clk);
    check("bounce_data", readdata, 32'hF);
    address = 2'd3;
    @(negedge clk);
    check("bounce_edge", readdata, BOUNCE_EDGE);
    wr_cycle(2'd3, 32'h2);
    @(negedge clk);

    // Mask, press bit1, then clear.
    wr_cycle(2'd1, 32'h3);
    address = 2'd3;
    in_port = 4'hD;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      if (k == L + 1) begin
        check("irq_pre", {31'b0, irq}, 32'h0);
        check("edge_pre", readdata, 32'h0);
      end
      if (k == L + 2) begin
        check("irq_rise", {31'b0, irq}, 32'h1);
        check("edge_set", readdata, 32'h2);
      end
    end
    repeat (6) @(negedge clk);
    check("irq_held", {31'b0, irq}, 32'h1);
    wr_cycle(2'd3, 32'h2);
    check("irq_lag", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_fall", {31'b0, irq}, 32'h0);
    check("edge_cleared", readdata, 32'h0);

    // Edge on bit0 collides with a write-1-to-clear of bit0.
    in_port = 4'hF;
    repeat (L + 3) @(negedge clk);
    in_port = 4'hE;
    repeat (L) @(negedge clk);
    wr_cycle(2'd3, 32'h1);
    @(negedge clk);
    check("collide_edge", readdata, 32'h1);
    check("collide_irq", {31'b0, irq}, 32'h1);
    wr_cycle(2'd3, 32'h1);
    @(negedge clk);
    check("collide_clear", readdata, 32'h0);

    // Reset in the middle of a debounce count.
    in_port = 4'hF;
    repeat (L + 3) @(negedge clk);
    in_port = 4'hD;
    repeat (L + 3) @(negedge clk);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    address = 2'd1;
    in_port = 4'hC;
    repeat (SYNC + 5) @(negedge clk);
    check("pre_reset_mask", readdata, 32'h3);
    reset_n = 1'b0;
    #1;
    check("midreset_rd", readdata, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    address = 2'd0;
    reset_n = 1'b1;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      if (k == L)     check("rst_full_hold", readdata, 32'hF);
      if (k == L + 1) check("rst_full_fall", readdata, 32'hC);
    end
    address = 2'd1;
    @(negedge clk);
    check("rst_mask_cleared", readdata, 32'h0);
    check("rst_irq_off", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
